// File: rtl/current_adc_stream_source_if.sv
// Valid/ready stream carrying one packed ADC conversion frame per beat.
// The source drives data/valid, the sink drives ready.
interface current_adc_stream_source_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/current_adc_stream_source.sv
// Current-sense ADC frame reader: 3-wire SPI master feeding one stream beat per frame.
// Define CURRENT_ADC_OFFSET_BINARY_EN to convert offset-binary samples to two's complement.
module current_adc_stream_source #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_COUNT = 2,
  parameter int CLK_DIV    = 4,
  parameter int OVF_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trigger,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  input  logic                 adc_miso,
  output logic                 busy,
  output logic [OVF_WIDTH-1:0] overflow_count,
  current_adc_stream_source_if.master stream
);

  localparam int N     = DATA_WIDTH * DATA_COUNT;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TRAIL,
    S_LOAD
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [BIT_W-1:0] bit_q;
  logic [BIT_W-1:0] bit_d;
  logic             high_q;
  logic             high_d;
  logic             sample;
  logic             div_last;
  logic             bit_last;

  logic [N-1:0]     shreg;
  logic [N-1:0]     data_q;
  logic             valid_q;

  logic             ignored;
  logic             dropped;
  logic             take;
  logic [1:0]       ovf_inc;
  logic [OVF_WIDTH:0] ovf_sum;

  function automatic logic [N-1:0] to_out(
    input logic [N-1:0] raw
  );
    logic [N-1:0] v;
    v = raw;
`ifdef CURRENT_ADC_OFFSET_BINARY_EN
    for (int c = 0; c < DATA_COUNT; c++) begin
      v[c*DATA_WIDTH + DATA_WIDTH-1] =
        ~v[c*DATA_WIDTH + DATA_WIDTH-1];
    end
`endif
    return v;
  endfunction

  assign div_last = (div_q == DIV_W'(CLK_DIV-1));
  assign bit_last = (bit_q == BIT_W'(N-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      high_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      high_q  <= high_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    high_d  = high_q;
    sample  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_LEAD;
          div_d   = '0;
        end
      end
      S_LEAD: begin
        if (div_last) begin
          state_d = S_SHIFT;
          div_d   = '0;
          bit_d   = '0;
          high_d  = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (!div_last) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (high_q) begin
            sample = 1'b1;
            high_d = 1'b0;
          end else if (bit_last) begin
            state_d = S_TRAIL;
          end else begin
            high_d = 1'b1;
            bit_d  = bit_q + 1'b1;
          end
        end
      end
      S_TRAIL: begin
        if (div_last) begin
          state_d = S_LOAD;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pins follow the next state so they line up with it cycle-for-cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
      busy     <= 1'b0;
    end else begin
      adc_cs_n <= (state_d == S_IDLE) || (state_d == S_LOAD);
      adc_sclk <= (state_d == S_SHIFT) && high_d;
      busy     <= (state_d != S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
    end else if (sample) begin
      shreg <= {shreg[N-2:0], adc_miso};
    end
  end

  assign take    = (state_q == S_LOAD) &&
                   (!valid_q || stream.out_ready);
  assign dropped = (state_q == S_LOAD) &&
                   valid_q && !stream.out_ready;
  assign ignored = trigger && (state_q != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (take) begin
      data_q  <= to_out(shreg);
      valid_q <= 1'b1;
    end else if (valid_q && stream.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign stream.out_data  = data_q;
  assign stream.out_valid = valid_q;

  // An ignored trigger and a dropped frame can land in the same cycle.
  assign ovf_inc = {1'b0, ignored} + {1'b0, dropped};
  assign ovf_sum = {1'b0, overflow_count} +
                   (OVF_WIDTH+1)'(ovf_inc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_count <= '0;
    end else if (ovf_sum[OVF_WIDTH]) begin
      overflow_count <= '1;
    end else begin
      overflow_count <= ovf_sum[OVF_WIDTH-1:0];
    end
  end

endmodule

// File: doc/current_adc_stream_source.md
# current_adc_stream_source

Drives the external current-sense ADC over a 3-wire SPI-style link and turns each conversion frame into one packed valid/ready stream beat for the downstream current FIR filter. Each `trigger` pulse (PWM-synchronous, from the motor timing block) starts one frame that reads `DATA_COUNT` channels of `DATA_WIDTH` bits. The result is held in a single output register under valid/ready handshake. Lost triggers and dropped frames are counted.

## Interface
- `DATA_WIDTH`, 16, bits per channel sample.
- `DATA_COUNT`, 2, channels per frame; channel 0 is read first.
- `CLK_DIV`, 4, clk cycles per SCLK half-period; legal range ≥ 2.
- `OVF_WIDTH`, 8, width of the saturating overflow counter.
- `clk` in, 1: system clock.
- `reset` in, 1: asynchronous, active-low.
- `trigger` in, 1: single-cycle frame start request.
- `adc_cs_n` out, 1: ADC chip select, active-low.
- `adc_sclk` out, 1: ADC serial clock, idle low.
- `adc_miso` in, 1: ADC serial data, MSB first. The ADC updates it on the SCLK falling edge. It is already synchronised to `clk` externally.
- `out_data` out, `DATA_WIDTH*DATA_COUNT`: packed samples. Channel 0 occupies the MSBs (`{ch0, ch1, ...}`).
- `out_valid` out, 1: `out_data` holds an unconsumed frame.
- `out_ready` in, 1: downstream accept.
- `busy` out, 1: a frame is in progress (`cs_n` low or LOAD state).
- `overflow_count` out, `OVF_WIDTH`: saturating count of ignored triggers plus dropped frames.

## Operation
- Total bits per frame: N = `DATA_WIDTH*DATA_COUNT`.
- States:
  - IDLE: `cs_n`=1, `sclk`=0. `trigger`=1 → LEAD.
  - LEAD: `cs_n`=0, `sclk`=0, lasts `CLK_DIV` cycles → SHIFT.
  - SHIFT: N bits. Each bit is `CLK_DIV` cycles with `sclk`=1, then `CLK_DIV` cycles with `sclk`=0. `adc_miso` is captured into the shift register on the last clk cycle of each high phase. After the low phase of bit N-1 → TRAIL.
  - TRAIL: `cs_n`=0, `sclk`=0, lasts `CLK_DIV` cycles → LOAD.
  - LOAD: `cs_n`=1, 1 cycle. If `out_valid`=0, copy the shift register to `out_data` and set `out_valid`. Otherwise discard the frame and increment `overflow_count`. → IDLE.
- `trigger` in any state other than IDLE is ignored and increments `overflow_count`.
- `overflow_count` saturates at all-ones and clears only on reset.
- Output register:
  - `out_valid` clears on a cycle where `out_valid && out_ready`.
  - `out_data` is stable while `out_valid`=1.
  - `out_data` may hold stale values while `out_valid`=0.
- When LOAD coincides with a handshake on the old beat (`out_valid && out_ready` in the same cycle), the old beat is consumed and the new frame is loaded. `out_valid` stays 1 and no overflow is counted.
- Bit order: the first received bit is the MSB of channel 0. The last received bit is the LSB of channel `DATA_COUNT-1`.

## Timing
- Reset values: `adc_cs_n`=1, `adc_sclk`=0, `out_valid`=0, `out_data`=0, `busy`=0, `overflow_count`=0, state IDLE.
- Reset asserted mid-frame immediately forces these values; the partial frame is lost.
- All outputs are registered.
- Trigger sampled at edge T:
  - `cs_n` falls and `busy` rises at T+1.
  - The first `sclk` rise is at T+1+`CLK_DIV`.
  - `cs_n` stays low for (2N+2)·`CLK_DIV` cycles.
  - `out_valid` rises at T+2+(2N+2)·`CLK_DIV`, the cycle after `cs_n` rises.
- Defaults (N=32, `CLK_DIV`=4): `cs_n` low for 264 cycles; `out_valid` at T+266.
- Minimum trigger period for no ignored triggers: (2N+2)·`CLK_DIV`+2 cycles.
- A trigger is accepted in the cycle immediately after LOAD.

## Configuration
- `CURRENT_ADC_OFFSET_BINARY_EN`, defined: the ADC is treated as offset-binary. The MSB of every channel is inverted at LOAD, so `out_data` is two's complement.
- Undefined: raw ADC bits pass to `out_data` unchanged.

## Test plan
- **Single frame, macro undefined:** ADC model returns 0x03E8, 0xFC18; `out_ready`=1 → one beat with `out_data`=0x03E8FC18 at T+266, `cs_n` low exactly 264 cycles, 32 SCLK rising edges.
- **Single frame, macro defined:** ADC model returns 0x83E8, 0x7C18 → `out_data`=0x03E8FC18.
- **Backpressure:** `out_ready`=0; trigger every 300 cycles, 3 times → first frame held and stable, `overflow_count`=2. Raise `out_ready` → exactly one beat with the first frame's data.
- **Trigger while busy:** triggers at T and T+100 → one frame only, `overflow_count`=1, `sclk` edge count unchanged.
- **LOAD with simultaneous handshake:** `out_ready` pulsed exactly in the LOAD cycle with `out_valid`=1 → new data present, `out_valid` continuous, `overflow_count` unchanged.
- **Reset mid-SHIFT:** reset asserted at bit 10 → `cs_n`=1 and `sclk`=0 immediately, no beat produced. The next trigger after reset release yields a correct full frame.
